// File: rtl/recfn_to_fn_seq.sv
// Multi-cycle HardFloat recoded-to-IEEE converter with go/done handshake.
// Subnormal results are denormalized by a one-bit-per-cycle right shifter.
module recfn_to_fn_seq #(
    parameter int expWidth    = 8,
    parameter int sigWidth    = 24,
    parameter int inputWidth  = 33,
    parameter int outputWidth = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   go,
    input  logic [inputWidth-1:0]  in_,
    output logic [outputWidth-1:0] out,
    output logic                   done
);

    localparam int DW = $clog2(sigWidth + 1);

    localparam logic [expWidth:0] MIN_NORM_EXP = (expWidth + 1)'((2 ** (expWidth - 1)) + 2);
    localparam logic [expWidth:0] SUB_BASE     = (expWidth + 1)'((2 ** (expWidth - 1)) + 1);
    localparam logic [expWidth:0] EXP_BIAS     = (expWidth + 1)'((2 ** (expWidth - 1)) + 1);
    localparam logic [expWidth:0] SIG_W_E      = (expWidth + 1)'(sigWidth);
    localparam logic [DW-1:0]     SIG_W_D      = DW'(sigWidth);
    localparam logic [DW-1:0]     CNT_ZERO     = DW'(0);
    localparam logic [DW-1:0]     CNT_ONE      = DW'(1);
    localparam logic [expWidth-1:0] EXP_ZERO   = {expWidth{1'b0}};
    localparam logic [expWidth-1:0] EXP_ONES   = {expWidth{1'b1}};
    localparam logic [sigWidth-2:0] FRACT_ZERO = {(sigWidth - 1){1'b0}};
    localparam logic [sigWidth-1:0] SIG_ZERO   = {sigWidth{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state_r;
    logic [DW-1:0]           cnt_r;
    logic [sigWidth-1:0]     sig_r;
    logic                    sign_r;
    logic [expWidth-1:0]     exp_r;
    logic [outputWidth-1:0]  out_r;
    logic                    done_r;

    logic                    signIn_s;
    logic [expWidth:0]       expIn_s;
    logic [sigWidth-2:0]     fractIn_s;
    logic [2:0]              e3_s;
    logic                    isZero_s;
    logic                    isInf_s;
    logic                    isNaN_s;
    logic                    isSub_s;
    logic [expWidth:0]       subDist_s;
    logic [expWidth:0]       expDiff_s;
    logic [DW-1:0]           dist_s;
    logic [expWidth-1:0]     expRes_s;
    logic [sigWidth-2:0]     fractRes_s;
    logic [sigWidth-1:0]     sigLoad_s;
    logic [sigWidth-1:0]     sigShift_s;

    // Classify the incoming operand and precompute exponent, fraction and shift distance.
    always_comb begin
        signIn_s   = in_[inputWidth-1];
        expIn_s    = in_[inputWidth-2 -: (expWidth + 1)];
        fractIn_s  = in_[sigWidth-2:0];
        e3_s       = expIn_s[expWidth -: 3];
        isZero_s   = 1'b0;
        isInf_s    = 1'b0;
        isNaN_s    = 1'b0;
        isSub_s    = 1'b0;
        case (e3_s)
            3'b000:  isZero_s = 1'b1;
            3'b110:  isInf_s  = 1'b1;
            3'b111:  isNaN_s  = 1'b1;
            default: isSub_s  = (expIn_s < MIN_NORM_EXP);
        endcase

        subDist_s = SUB_BASE - expIn_s;
        expDiff_s = expIn_s - EXP_BIAS;
        if (!isSub_s) begin
            dist_s = CNT_ZERO;
        end else if (subDist_s > SIG_W_E) begin
            dist_s = SIG_W_D;
        end else begin
            dist_s = subDist_s[DW-1:0];
        end

        if (isSub_s) begin
            sigLoad_s = {1'b1, fractIn_s} >> 1;
        end else begin
            sigLoad_s = {1'b0, fractIn_s};
        end

        if (isZero_s || isSub_s) begin
            expRes_s = EXP_ZERO;
        end else if (isInf_s || isNaN_s) begin
            expRes_s = EXP_ONES;
        end else begin
            expRes_s = expDiff_s[expWidth-1:0];
        end

        // A subnormal reaching here with d=0 has its fraction already aligned in sigLoad.
        if (isZero_s || isInf_s) begin
            fractRes_s = FRACT_ZERO;
        end else if (isSub_s) begin
            fractRes_s = sigLoad_s[sigWidth-2:0];
        end else begin
            fractRes_s = fractIn_s;
        end

        sigShift_s = sig_r >> 1;
    end

    // Conversion FSM: capture, iterative denormalization, single-cycle done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            sig_r   <= SIG_ZERO;
            sign_r  <= 1'b0;
            exp_r   <= EXP_ZERO;
            out_r   <= {outputWidth{1'b0}};
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (go) begin
                        sign_r <= signIn_s;
                        exp_r  <= expRes_s;
                        sig_r  <= sigLoad_s;
                        if (dist_s != CNT_ZERO) begin
                            cnt_r   <= dist_s;
                            state_r <= SHIFT;
                        end else begin
                            out_r   <= {signIn_s, expRes_s, fractRes_s};
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    sig_r <= sigShift_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        out_r   <= {sign_r, exp_r, sigShift_s[sigWidth-2:0]};
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign out  = out_r;
    assign done = done_r;

endmodule

// File: tb/tb_recfn_to_fn_seq.sv
// Scoreboard bench for recfn_to_fn_seq: directed vectors, back-to-back go, reset mid-shift
// and an IEEE -> recoded -> IEEE round trip through a bench-side recoder.
module tb_recfn_to_fn_seq;

    logic        clk;
    logic        reset;
    logic        go;
    logic [32:0] in_;
    logic [31:0] out;
    logic        done;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] val;
        int          doneCyc;
        string       nm;
    } exp_t;

    exp_t q[$];

    recfn_to_fn_seq #(
        .expWidth(8), .sigWidth(24), .inputWidth(33), .outputWidth(32)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .in_(in_), .out(out), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Leading-zero count of a 23-bit IEEE fraction.
    function automatic int clz23(input logic [22:0] f);
        int n;
        logic found;
        n = 0;
        found = 1'b0;
        for (int b = 22; b >= 0; b--) begin
            if (!found) begin
                if (f[b]) found = 1'b1;
                else n++;
            end
        end
        return n;
    endfunction

    // Reference binary32 -> recoded conversion (HardFloat recFNFromFN).
    function automatic logic [32:0] recode(input logic [31:0] f);
        logic [7:0]  ei;
        logic [22:0] fi;
        logic [22:0] subF;
        logic [8:0]  adj;
        logic [8:0]  re;
        int          nd;
        logic        isZero;
        logic        isSpec;
        ei = f[30:23];
        fi = f[22:0];
        nd = clz23(fi);
        subF = fi << (nd + 1);
        if (ei == 8'd0) adj = (9'(nd) ^ 9'h1FF) + 9'd130;
        else            adj = {1'b0, ei} + 9'd129;
        isZero = (ei == 8'd0) && (fi == 23'd0);
        isSpec = (adj[8:7] == 2'b11);
        re[5:0] = adj[5:0];
        if (isSpec)      re[8:6] = {2'b11, fi != 23'd0};
        else if (isZero) re[8:6] = 3'b000;
        else             re[8:6] = adj[8:6];
        return {f[31], re, (ei == 8'd0) ? subF : fi};
    endfunction

    // Denormalization distance: position of the leading one of a subnormal fraction.
    function automatic int distOf(input logic [31:0] f);
        if (f[30:23] == 8'd0 && f[22:0] != 23'd0) return clz23(f[22:0]);
        return 0;
    endfunction

    task automatic push(input logic [31:0] v, input int dc, input string nm);
        exp_t e;
        e.val = v;
        e.doneCyc = dc;
        e.nm = nm;
        q.push_back(e);
    endtask

    task automatic waitDrain(input int budget);
        for (int k = 0; k < budget && q.size() != 0; k++) begin
            @(negedge clk);
            #2;
        end
        if (q.size() != 0) begin
            nChecks++;
            nFails++;
            $display("FAIL timeout(%s): %0d results still pending, expected none", q[0].nm, q.size());
            q.delete();
        end
    endtask

    task automatic issue(input logic [32:0] v, input logic [31:0] e, input int d, input string nm);
        @(negedge clk);
        in_ = v;
        go  = 1'b1;
        push(e, cyc + 1 + d, nm);
        @(negedge clk);
        go = 1'b0;
        waitDrain(d + 6);
    endtask

    logic [32:0] bbIn [5];
    logic [31:0] bbOut[5];
    int          bbD  [5];

    initial begin
        logic [31:0] f;
        int          e;
        logic        prevDone;

        reset = 1'b0;
        go    = 1'b0;
        in_   = 33'd0;
        #1;
        nChecks++;
        if (out !== 32'd0 || done !== 1'b0) begin
            nFails++;
            $display("FAIL reset_state: got out=%h done=%b expected out=00000000 done=0", out, done);
        end

        // Monitor: compare each done against the scoreboard head (value and cycle).
        prevDone = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (done === 1'b1) begin
                    nChecks++;
                    if (prevDone) begin
                        nFails++;
                        $display("FAIL done_pulse: got done high 2 cycles expected 1 at cycle %0d", cyc);
                    end
                    if (q.size() == 0) begin
                        nFails++;
                        $display("FAIL spurious_done: got done at cycle %0d expected none", cyc);
                    end else begin
                        exp_t x;
                        x = q.pop_front();
                        nChecks++;
                        if (out !== x.val) begin
                            nFails++;
                            $display("FAIL out(%s): got %h expected %h", x.nm, out, x.val);
                        end
                        if (cyc != x.doneCyc) begin
                            nFails++;
                            $display("FAIL latency(%s): got done at cycle %0d expected %0d", x.nm, cyc, x.doneCyc);
                        end
                    end
                end
                prevDone = (done === 1'b1);
            end
        join_none

        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Directed vectors.
        issue(33'h0_8000_0000, 32'h3F800000, 0,  "one");
        issue(33'h0_3580_0000, 32'h00000001, 22, "min_sub");
        issue(33'h0_4080_0000, 32'h00400000, 0,  "top_sub");
        issue(33'h1_0000_0000, 32'h80000000, 0,  "neg_zero");
        issue(33'h1_C000_0000, 32'hFF800000, 0,  "neg_inf");
        issue(33'h0_E000_0001, 32'h7F800001, 0,  "nan_payload");
        issue(33'h1_E040_0005, 32'hFFC00005, 0,  "neg_nan");
        issue(33'h0_8040_0000, 32'h3FC00000, 0,  "one_half");
        issue(33'h0_4000_0000, 32'h00200000, 1,  "sub_d1");
        issue(33'h0_2000_0000, 32'h00000000, 24, "clamp");

        // Back-to-back: go held high, captures every d+2 cycles.
        bbIn[0] = 33'h0_8000_0000; bbOut[0] = 32'h3F800000; bbD[0] = 0;
        bbIn[1] = 33'h0_4000_0000; bbOut[1] = 32'h00200000; bbD[1] = 1;
        bbIn[2] = 33'h1_8080_0000; bbOut[2] = 32'hC0000000; bbD[2] = 0;
        bbIn[3] = 33'h0_3F80_0000; bbOut[3] = 32'h00100000; bbD[3] = 2;
        bbIn[4] = 33'h0_8040_0000; bbOut[4] = 32'h3FC00000; bbD[4] = 0;
        @(negedge clk);
        go = 1'b1;
        e  = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            in_ = bbIn[i];
            push(bbOut[i], e + bbD[i], "b2b");
            while (cyc < e) @(negedge clk);
            e = e + bbD[i] + 2;
        end
        go = 1'b0;
        waitDrain(10);

        // Reset mid-shift: the in-flight conversion must vanish without done.
        @(negedge clk);
        in_ = 33'h0_3580_0000;
        go  = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        nChecks++;
        if (out !== 32'd0 || done !== 1'b0) begin
            nFails++;
            $display("FAIL reset_midshift: got out=%h done=%b expected out=00000000 done=0", out, done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        issue(33'h0_8000_0000, 32'h3F800000, 0, "after_reset");

        // Round trip through the bench recoder.
        for (int i = 0; i < 14; i++) begin
            f = $urandom();
            if (i % 3 == 0) f[30:23] = 8'h00;
            if (i == 4)     f[30:23] = 8'hFF;
            if (i == 7)     f[22:0]  = 23'd0;
            issue(recode(f), f, distOf(f), "round_trip");
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/recfn_to_fn_seq.md
# recfn_to_fn_seq

Multi-cycle converter from HardFloat recoded format (expWidth+1 exponent bits) back to IEEE-754 binary format. It sits directly downstream of the fN-to-recoded converter and the recoded-format arithmetic units, and returns results to standard memory and register encoding. The block uses the Calyx go/done handshake. Subnormal outputs are denormalized by an iterative one-bit-per-cycle right shifter rather than a full barrel shifter, which trades latency for area.

## Interface
- expWidth, 8, IEEE exponent width
- sigWidth, 24, significand width including hidden bit
- inputWidth, 33, recoded width; must equal expWidth+sigWidth+1
- outputWidth, 32, IEEE width; must equal expWidth+sigWidth
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- go  input  1  start request; sampled only in IDLE
- in_  input  inputWidth  recoded operand {sign, exp[expWidth:0], fract[sigWidth-2:0]}
- out  output  outputWidth  IEEE result {sign, exp[expWidth-1:0], fract[sigWidth-2:0]}, registered
- done  output  1  one-cycle pulse; out valid and held from this cycle onward

## Operation
- Decode at capture, from recoded exp top 3 bits (e3):
  - zero: e3==000
  - inf: e3==110
  - NaN: e3==111
  - finite: otherwise
- minNormExp = 2^(expWidth-1)+2. A finite value is subnormal iff exp < minNormExp.
- Shift distance d:
  - subnormal: d = min(minNormExp-1-exp, sigWidth); width clog2(sigWidth+1)
  - all other classes: d = 0
- Working register sig[sigWidth-1:0] loads {1'b1, fract} >> 1 for subnormal inputs, else {1'b0, fract}.
- Result exponent (latched at capture):
  - zero: 0
  - subnormal: 0
  - inf/NaN: all ones
  - normal: exp - (2^(expWidth-1)+1), truncated to expWidth bits
- Result fraction:
  - zero: 0
  - inf: 0
  - NaN: fract passthrough (payload preserved, no canonicalization)
  - normal: fract
  - subnormal: sig[sigWidth-2:0] after d further right shifts
- Sign always passes through, including -0, -inf and NaN.
- FSM states:
  - IDLE: on go=1, capture in_ and decode. Go to SHIFT with cnt=d if d>0, else to DONE and write out.
  - SHIFT: each cycle sig >>= 1 (zero fill) and cnt -= 1. When cnt reaches 1, that final shift completes, out is written, and the FSM moves to DONE.
  - DONE: done=1, then unconditionally go to IDLE.
- go is ignored in SHIFT and DONE; in_ is not re-sampled after capture.
- If d clamps to sigWidth (malformed recoded exponent), the fraction resolves to 0.

## Timing
- Reset (reset=0, async): state=IDLE, done=0, out=0, cnt=0, sig=0. Takes effect immediately, including mid-SHIFT; the in-flight conversion is discarded and no done is issued.
- Latency: go sampled at edge E0; done high in the cycle after edge E0+d.
  - d=0 (normal, zero, inf, NaN, top-bit subnormal): 1 cycle.
  - d>0: d+1 cycles.
  - Worst legal case is the smallest subnormal, d = sigWidth-2: 23 cycles at defaults.
- done is high for exactly one cycle. out changes only on the edge that enters DONE.
- If go stays high through DONE, a new conversion is captured at the edge after DONE. Minimum issue interval is d+2 cycles.
- Reset deassertion is synchronized externally; go must be low for at least the first cycle after reset release.

## Test plan
- Normal: in_=33'h0_8000_0000 (recoded 1.0), go pulse -> done 1 cycle after go, out=32'h3F800000.
- Smallest subnormal: in_=33'h0_3580_0000 -> d=22, done 23 cycles after go, out=32'h00000001; done low throughout SHIFT.
- Top-bit subnormal and zero: in_=33'h0_4080_0000 -> out=32'h00400000 in 1 cycle; in_=33'h1_0000_0000 -> out=32'h80000000 (-0) in 1 cycle.
- Specials:
  - in_=33'h1_C000_0000 -> out=32'hFF800000.
  - in_=33'h0_E000_0001 -> out=32'h7F800001 (NaN payload kept).
- Handshake: go held high continuously with alternating normal/subnormal operands -> each done is a single-cycle pulse, captures spaced d+2 cycles apart, no operand skipped or duplicated.
- Reset mid-shift: start the smallest-subnormal case, drive reset=0 at cycle 10 -> out=0 and done=0 immediately. After release, a fresh 1.0 conversion completes normally in 1 cycle.
- Round trip: random binary32 patterns through the fN-to-recoded converter then this block -> bit-exact equality for all non-NaN inputs; NaN inputs keep payload and sign.
